// File: rtl/div_signed_async.sv
// Sequential restoring signed divider, one quotient bit per enabled cycle; W+1 enabled cycles from accept to done.
// No backpressure: start is taken only when idle and en=1; en=0 freezes every register.
module div_signed_async #(
    parameter int M = 8,
    parameter int N = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [M+N-1:0]   a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   q,
    output logic [N-1:0]     r,
    output logic             dz
);
    localparam int W  = M + N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   rem;
    logic [W-1:0]   dvd;
    logic [N:0]     bmag;
    logic           neg_q, neg_r, zero;

    logic           accept;
    logic [W-1:0]   a_mag;
    logic [N:0]     rem_sh;
    logic [N+1:0]   diff;
    logic           borrow;

    assign accept = en && start && (state == IDLE);
    assign busy   = (state != IDLE);

    // Magnitudes are taken unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
    assign a_mag  = a[W-1] ? (~a + 1'b1) : a;
    assign rem_sh = {rem, dvd[W-1]};
    assign diff   = {1'b0, rem_sh} - {1'b0, bmag};
    assign borrow = diff[N+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    if (start) state_nxt = CALC;
                CALC:    if (cnt == '0) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            bmag  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            zero  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dvd   <= a_mag;
                bmag  <= {1'b0, b[N-1] ? (~b + 1'b1) : b};
                neg_r <= a[W-1];
                neg_q <= a[W-1] ^ b[N-1];
                zero  <= (b == '0);
                rem   <= '0;
                cnt   <= CW'(W - 1);
            end else if (en && state == CALC) begin
                // A kept difference is always below |b|, so it fits in N bits.
                rem <= borrow ? N'(rem_sh) : N'(diff);
                dvd <= {dvd[W-2:0], ~borrow};
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (en && state == FIX) begin
                q    <= zero ? '1 : (neg_q ? (~dvd + 1'b1) : dvd);
                r    <= zero ? '0 : (neg_r ? (~rem + 1'b1) : rem);
                dz   <= zero;
                done <= 1'b1;
            end
        end
    end
endmodule
